// File: rtl/ddr3_arb_pkg.sv
// ddr3_arb_pkg: MIG command encodings and arbiter FSM states shared across the arbiter slice
package ddr3_arb_pkg;
    typedef logic [2:0] app_cmd_t;
    localparam app_cmd_t APP_CMD_RD = 3'b001;
    localparam app_cmd_t APP_CMD_WR = 3'b000;
    typedef enum logic [1:0] {IDLE, WDATA, CMD} arb_state_t;
endpackage

// File: rtl/ddr3_app_arbiter_if.sv
// ddr3_app_arbiter_if: client request/read-return bundle and MIG user (app_*) bundle
interface ddr3_arb_client_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 512,
    parameter int MASK_WIDTH = 64
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    modport master (output cmd_valid, cmd_rd, addr, wdata, wmask, input cmd_ready, rd_data, rd_valid);
    modport slave  (input cmd_valid, cmd_rd, addr, wdata, wmask, output cmd_ready, rd_data, rd_valid);
endinterface

interface ddr3_app_if #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 512,
    parameter int MASK_WIDTH = 64
);
    import ddr3_arb_pkg::*;
    logic [ADDR_WIDTH-1:0] addr;
    app_cmd_t              cmd;
    logic                  en;
    logic                  rdy;
    logic [DATA_WIDTH-1:0] wdf_data;
    logic [MASK_WIDTH-1:0] wdf_mask;
    logic                  wdf_wren;
    logic                  wdf_end;
    logic                  wdf_rdy;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_data_valid;
    logic                  rd_data_end;
    modport master (output addr, cmd, en, wdf_data, wdf_mask, wdf_wren, wdf_end,
                    input rdy, wdf_rdy, rd_data, rd_data_valid, rd_data_end);
    modport slave  (input addr, cmd, en, wdf_data, wdf_mask, wdf_wren, wdf_end,
                    output rdy, wdf_rdy, rd_data, rd_data_valid, rd_data_end);
endinterface

// File: rtl/ddr3_arb_tag_fifo.sv
// ddr3_arb_tag_fifo: 1-bit port-tag FIFO recording which requester owns each outstanding read
module ddr3_arb_tag_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic                       wr_data,
    input  logic                       rd_en,
    output logic                       rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wp, rp;
    logic             push, pop;

    assign pop     = rd_en & ~empty;
    assign push    = wr_en & (~full | pop);
    assign rd_data = mem[rp];
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push) mem[wp] <= wr_data;
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
endmodule

// File: rtl/ddr3_app_arbiter.sv
// ddr3_app_arbiter: round-robin sharing of one MIG app_* port between two single-beat clients
module ddr3_app_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 512,
    parameter int MASK_WIDTH = 64,
    parameter int TAG_DEPTH  = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              init_calib_complete,
    ddr3_arb_client_if.slave  p0,
    ddr3_arb_client_if.slave  p1,
    ddr3_app_if.master        app,
    output logic              rd_orphan_err
);
    localparam int CW = $clog2(TAG_DEPTH) + 1;
    localparam logic [CW-1:0] TAG_MAX = CW'(TAG_DEPTH);

    arb_state_t            state, state_nx;
    logic                  last_grant;
    logic                  rd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [MASK_WIDTH-1:0] mask_q;
    logic                  elig0, elig1, grant0, grant1, grant, sel_rd, idle;
    logic                  tag_push, tag_pop, tag_head, tag_full, tag_empty;
    logic [CW-1:0]         tag_count;

    // eligibility looks only at the registered tag count, so a same-cycle pop never frees a slot early
    assign elig0  = p0.cmd_valid & init_calib_complete & (~p0.cmd_rd | (tag_count < TAG_MAX));
    assign elig1  = p1.cmd_valid & init_calib_complete & (~p1.cmd_rd | (tag_count < TAG_MAX));
    assign idle   = (state == IDLE) & ~sys_rst;
    assign grant0 = idle & elig0 & (~elig1 | last_grant);
    assign grant1 = idle & elig1 & (~elig0 | ~last_grant);
    assign grant  = grant0 | grant1;
    assign sel_rd = grant1 ? p1.cmd_rd : p0.cmd_rd;

    assign p0.cmd_ready = grant0;
    assign p1.cmd_ready = grant1;

    assign app.addr     = addr_q;
    assign app.cmd      = rd_q ? APP_CMD_RD : APP_CMD_WR;
    assign app.wdf_data = data_q;
    assign app.wdf_mask = mask_q;

    always_comb begin
        state_nx     = state;
        app.en       = state == CMD;
        app.wdf_wren = state == WDATA;
        app.wdf_end  = state == WDATA;
        if (idle && grant) state_nx = sel_rd ? CMD : WDATA;
        if (state == WDATA && app.wdf_rdy) state_nx = CMD;
        if (state == CMD && app.rdy) state_nx = IDLE;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            rd_q          <= 1'b0;
            addr_q        <= '0;
            data_q        <= '0;
            mask_q        <= '0;
            rd_orphan_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (grant) begin
                last_grant <= grant1;
                rd_q       <= sel_rd;
                addr_q     <= grant1 ? p1.addr : p0.addr;
                data_q     <= grant1 ? p1.wdata : p0.wdata;
                mask_q     <= grant1 ? p1.wmask : p0.wmask;
            end
            if (app.rd_data_valid && app.rd_data_end && tag_empty) rd_orphan_err <= 1'b1;
        end
    end

    // tag pushed on the read command's acceptance edge, popped on the last return beat
    assign tag_push = (state == CMD) & app.rdy & rd_q & ~tag_full;
    assign tag_pop  = app.rd_data_valid & app.rd_data_end & ~sys_rst;

    ddr3_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .wr_en   (tag_push),
        .wr_data (grant1 ? 1'b1 : last_grant),
        .rd_en   (tag_pop),
        .rd_data (tag_head),
        .count   (tag_count),
        .full    (tag_full),
        .empty   (tag_empty)
    );

    assign p0.rd_valid = tag_pop & ~tag_empty & ~tag_head;
    assign p1.rd_valid = tag_pop & ~tag_empty & tag_head;
    assign p0.rd_data  = app.rd_data;
    assign p1.rd_data  = app.rd_data;
endmodule
